// File: rtl/led_speed_ctrl.sv
// Button-driven blink-rate controller: short press cycles the speed, long press toggles pause.
// Button path: 2 sync flops plus DEBOUNCE_CYC; oTick is a one-cycle strobe every period+1 active cycles.
module led_speed_ctrl #(
   parameter int          DEBOUNCE_CYC = 270000,
   parameter int          LONG_CYC     = 54000000,
   parameter logic [25:0] P_SLOW       = 26'd27000000 - 26'd1,
   parameter logic [25:0] P_MID        = 26'd13500000 - 26'd1,
   parameter logic [25:0] P_FAST       = 26'd2700000 - 26'd1
) (
   input  logic        CLK,
   input  logic        RESETn,
   input  logic        iBtnn,
   output logic [25:0] oPeriod,
   output logic [1:0]  oSpeed,
   output logic        oPaused,
   output logic        oTick
);

   localparam int              DW       = $clog2(DEBOUNCE_CYC + 1);
   localparam int              HW       = $clog2(LONG_CYC + 1);
   localparam logic [DW-1:0]   DEB_LAST = DW'(DEBOUNCE_CYC - 1);
   localparam logic [HW-1:0]   HOLD_MAX = HW'(LONG_CYC);

   typedef enum logic [1:0] {IDLE, HELD, LONG, WAIT_REL} state_t;

   logic          r_sync1;
   logic          r_sync2;
   logic          w_btn;
   logic          r_deb;
   logic          r_deb_q;
   logic          w_rise;
   logic [DW-1:0] r_stab_cnt;
   logic [DW-1:0] r_arm_cnt;
   logic          r_armed;
   state_t        r_state;
   logic [HW-1:0] r_hold;
   logic          r_adv;
   logic          r_paused;
   logic [1:0]    r_speed;
   logic [25:0]   r_cnt;
   logic [25:0]   w_period;

   assign w_btn  = ~r_sync2;
   assign w_rise = r_deb & ~r_deb_q;

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= iBtnn;
         r_sync2 <= r_sync1;
      end
   end

   // A press still held across reset must be seen released before a new press is accepted.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         r_deb      <= 1'b0;
         r_deb_q    <= 1'b0;
         r_stab_cnt <= '0;
         r_arm_cnt  <= '0;
         r_armed    <= 1'b0;
      end else begin
         r_deb_q <= r_deb;
         if (w_btn != r_deb) begin
            if (r_stab_cnt == DEB_LAST) begin
               r_deb      <= w_btn;
               r_stab_cnt <= '0;
            end else begin
               r_stab_cnt <= r_stab_cnt + 1'b1;
            end
         end else begin
            r_stab_cnt <= '0;
         end
         if (!r_armed) begin
            if (!w_btn && !r_deb) begin
               if (r_arm_cnt == DEB_LAST) r_armed <= 1'b1;
               else                       r_arm_cnt <= r_arm_cnt + 1'b1;
            end else begin
               r_arm_cnt <= '0;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         r_state  <= IDLE;
         r_hold   <= '0;
         r_adv    <= 1'b0;
         r_paused <= 1'b0;
      end else begin
         r_adv <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_rise && r_armed) begin
                  r_state <= HELD;
                  r_hold  <= '0;
               end
            end
            HELD: begin
               if (r_hold == HOLD_MAX) begin
                  r_state <= LONG;
               end else if (!r_deb) begin
                  r_adv   <= 1'b1;
                  r_state <= IDLE;
               end else begin
                  r_hold <= r_hold + 1'b1;
               end
            end
            LONG: begin
               r_paused <= ~r_paused;
               r_state  <= WAIT_REL;
            end
            WAIT_REL: begin
               if (!r_deb) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_comb begin
      w_period = P_SLOW;
      case (r_speed)
         2'd1:    w_period = P_MID;
         2'd2:    w_period = P_FAST;
         default: w_period = P_SLOW;
      endcase
   end

   // A speed change restarts the period; ">=" lets a stale count above a shorter period wrap at once.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         r_speed <= 2'd0;
         r_cnt   <= '0;
      end else if (r_adv) begin
         r_speed <= (r_speed == 2'd2) ? 2'd0 : r_speed + 2'd1;
         r_cnt   <= '0;
      end else if (!r_paused) begin
         if (r_cnt >= w_period) r_cnt <= '0;
         else                   r_cnt <= r_cnt + 26'd1;
      end
   end

   assign oPeriod = w_period;
   assign oSpeed  = r_speed;
   assign oPaused = r_paused;
   assign oTick   = !r_paused && !r_adv && (r_cnt >= w_period);

endmodule

// File: tb/tb_led_speed_ctrl.sv
// Scoreboard bench for led_speed_ctrl with small debounce, hold and period values.
module tb_led_speed_ctrl;

   localparam int SHORT_LAT = 16;   // press start -> oSpeed change, 8-cycle press
   localparam int LONG_LAT  = 29;   // press start -> oPaused change

   logic        CLK    = 1'b0;
   logic        RESETn = 1'b0;
   logic        iBtnn  = 1'b1;
   logic [25:0] oPeriod;
   logic [1:0]  oSpeed;
   logic        oPaused;
   logic        oTick;

   int checks   = 0;
   int errors   = 0;
   int cyc      = 0;
   int tick_cnt = 0;
   int g        = -1;
   logic [1:0] prev_sp   = 2'd0;
   logic       prev_pz   = 1'b0;
   logic       prev_tick = 1'b0;

   typedef struct packed {
      logic [1:0]  sp;
      logic        pz;
      logic [31:0] at;
   } exp_t;
   exp_t exp_q[$];

   led_speed_ctrl #(
      .DEBOUNCE_CYC(4),
      .LONG_CYC    (20),
      .P_SLOW      (26'd9),
      .P_MID       (26'd4),
      .P_FAST      (26'd1)
   ) dut (
      .CLK    (CLK),
      .RESETn (RESETn),
      .iBtnn  (iBtnn),
      .oPeriod(oPeriod),
      .oSpeed (oSpeed),
      .oPaused(oPaused),
      .oTick  (oTick)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   function automatic logic [25:0] exp_per(input logic [1:0] sp);
      case (sp)
         2'd0:    return 26'd9;
         2'd1:    return 26'd4;
         2'd2:    return 26'd1;
         default: return 26'h3FFFFFF;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: g tracks the cycles since the tick counter last restarted, frozen while paused.
   always @(negedge CLK) begin
      if (!RESETn) begin
         g         = -1;
         prev_sp   = 2'd0;
         prev_pz   = 1'b0;
         prev_tick = 1'b0;
      end else begin
         if (oSpeed != prev_sp) begin
            check("no_tick_in_change_cycle", {63'd0, prev_tick}, 64'd0);
            g = 0;
         end else if (prev_tick) begin
            g = 0;
         end else if (!prev_pz) begin
            g = g + 1;
         end
         if (oSpeed != prev_sp || oPaused != prev_pz) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_change actual speed=%0d paused=%0d cycle=%0d required no change",
                        oSpeed, oPaused, cyc);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("change_speed",  {62'd0, oSpeed},  {62'd0, e.sp});
               check("change_paused", {63'd0, oPaused}, {63'd0, e.pz});
               check("change_cycle",  64'(cyc),         {32'd0, e.at});
            end
         end
         if (oTick) begin
            tick_cnt++;
            check("tick_while_paused", {63'd0, oPaused}, 64'd0);
            check("tick_period",       {38'd0, oPeriod}, {38'd0, exp_per(oSpeed)});
            check("tick_spacing",      64'(g),           {38'd0, exp_per(oSpeed)});
         end
         prev_sp   = oSpeed;
         prev_pz   = oPaused;
         prev_tick = oTick;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic window(input int n, input int exp_ticks, input string name);
      int t0;
      t0 = tick_cnt;
      idle(n);
      check(name, 64'(tick_cnt - t0), 64'(exp_ticks));
   endtask

   task automatic short_press(input logic [1:0] sp, input logic pz);
      @(posedge CLK);
      #1;
      iBtnn = 1'b0;
      exp_q.push_back(exp_t'{sp, pz, 32'(cyc + SHORT_LAT)});
      idle(8);
      iBtnn = 1'b1;
   endtask

   task automatic long_press(input logic [1:0] sp, input logic pz);
      @(posedge CLK);
      #1;
      iBtnn = 1'b0;
      exp_q.push_back(exp_t'{sp, pz, 32'(cyc + LONG_LAT)});
      idle(40);
      iBtnn = 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_speed"},  {62'd0, oSpeed},  64'd0);
      check({tag, "_paused"}, {63'd0, oPaused}, 64'd0);
      check({tag, "_tick"},   {63'd0, oTick},   64'd0);
      check({tag, "_period"}, {38'd0, oPeriod}, 64'd9);
   endtask

   initial begin
      // Power-up reset
      idle(3);
      @(negedge CLK);
      check_reset_outputs("reset");
      @(posedge CLK);
      #1;
      RESETn = 1'b1;
      window(30, 3, "ticks_after_reset");

      // 3-cycle glitch must not register
      @(posedge CLK);
      #1;
      iBtnn = 1'b0;
      idle(3);
      iBtnn = 1'b1;
      window(30, 3, "ticks_after_glitch");

      // Short presses: speed 1, 2, 0
      short_press(2'd1, 1'b0);
      idle(12);
      window(20, 4, "ticks_speed1");
      short_press(2'd2, 1'b0);
      idle(12);
      window(20, 10, "ticks_speed2");
      short_press(2'd0, 1'b0);
      idle(12);
      window(20, 2, "ticks_speed0");

      // Long press pauses, second long press resumes from the held count
      long_press(2'd0, 1'b1);
      idle(10);
      window(20, 0, "ticks_paused");
      long_press(2'd0, 1'b0);
      window(20, 2, "ticks_resumed");

      // Short press while paused advances speed only
      long_press(2'd0, 1'b1);
      idle(10);
      short_press(2'd1, 1'b1);
      idle(12);
      window(20, 0, "ticks_paused_speed1");
      long_press(2'd1, 1'b0);
      window(20, 4, "ticks_unpaused_speed1");

      // Reset while the button is held, button still held after reset
      @(posedge CLK);
      #1;
      iBtnn = 1'b0;
      idle(10);
      RESETn = 1'b0;
      @(negedge CLK);
      check_reset_outputs("midhold_reset");
      idle(3);
      RESETn = 1'b1;
      window(30, 3, "ticks_held_after_reset");
      iBtnn = 1'b1;
      idle(30);
      short_press(2'd1, 1'b0);
      idle(12);
      window(20, 4, "ticks_after_repress");

      idle(5);
      check("pending_expectations", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_speed_ctrl.md
LED_SPEED_CTRL -- requirements
Module: led_speed_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYC, default 270000, the number of consecutive stable cycles (10 ms at 27 MHz) needed to accept a button level change.
REQ-002 SHALL have parameter LONG_CYC, default 54000000, the debounced hold length in cycles (2 s) that counts as a long press.
REQ-003 SHALL have parameter P_SLOW, default 26'd27000000-1, the terminal count for the 1 s period.
REQ-004 SHALL have parameter P_MID, default 26'd13500000-1, the terminal count for the 0.5 s period.
REQ-005 SHALL have parameter P_FAST, default 26'd2700000-1, the terminal count for the 0.1 s period.
REQ-006 SHALL have port CLK, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-007 SHALL have port RESETn, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port iBtnn, input, 1 bit: raw, asynchronous, active-low push button.
REQ-009 SHALL have port oPeriod, output, 26 bits: the currently selected terminal count.
REQ-010 SHALL have port oSpeed, output, 2 bits: the speed index (0=slow, 1=mid, 2=fast; 3 is never driven).
REQ-011 SHALL have port oPaused, output, 1 bit: 1 while ticking is suspended.
REQ-012 SHALL have port oTick, output, 1 bit: a one-cycle step strobe for the LED counter datapath.

Function
REQ-013 SHALL pass iBtnn through a 2-flop synchronizer and invert it, giving pressed=1; the synchronizer adds 2 cycles of latency.
REQ-014 SHALL flip the debounced level only after the synchronized input differs from it for DEBOUNCE_CYC consecutive cycles; any return to the debounced value clears the stability counter.
REQ-015 SHALL use a press FSM with states IDLE, HELD, LONG, WAIT_REL.
- IDLE to HELD on the debounced rising edge; the hold counter clears to 0.
- In HELD, the hold counter increments every cycle and saturates at LONG_CYC.
REQ-016 SHALL treat a debounced release in HELD with hold count < LONG_CYC as a short press: emit an internal one-cycle adv pulse and return to IDLE.
REQ-017 SHALL, when the hold count reaches LONG_CYC in HELD, enter LONG, toggle oPaused exactly once, then go to WAIT_REL.
REQ-018 SHALL go from WAIT_REL to IDLE on the debounced release, with no adv pulse.
REQ-019 SHALL advance oSpeed 0 to 1 to 2 to 0 on each adv pulse, wrapping from 2 back to 0; oSpeed changes in the cycle after adv.
REQ-020 SHALL accept adv while paused: the speed changes and oPaused is unchanged.
REQ-021 SHALL drive oPeriod combinationally from oSpeed: 0 gives P_SLOW, 1 gives P_MID, 2 gives P_FAST.
REQ-022 SHALL hold a 26-bit tick counter with this behaviour:
- When not paused and the counter is below oPeriod, it increments.
- When it equals oPeriod, oTick=1 for that cycle and the counter returns to 0.
REQ-023 SHALL, in the cycle oSpeed changes, reset the tick counter to 0 and force oTick=0; this takes priority over a terminal count in the same cycle.
REQ-024 SHALL, while oPaused=1, hold the tick counter and keep oTick=0; on resume, counting continues from the held value.
REQ-025 SHALL treat a counter value greater than oPeriod as terminal: it wraps to 0 with oTick=1, which guarantees recovery.
REQ-026 SHALL never assert oTick on two consecutive cycles, provided oPeriod is at least 1.

Reset
REQ-027 SHALL, while RESETn=0, asynchronously force:
- oSpeed=0, oPaused=0, oTick=0, oPeriod=P_SLOW;
- tick counter=0, press FSM=IDLE;
- stability and hold counters=0;
- synchronizer flops=1 (released) and debounced level=released.
REQ-028 SHALL discard a press that is in progress when reset asserts; after release of reset, a new debounced edge is required.
REQ-029 SHALL resume normal operation on the first CLK edge after RESETn deasserts.

Verification (DEBOUNCE_CYC=4, LONG_CYC=20, P_SLOW=9, P_MID=4, P_FAST=1)
REQ-030 SHALL cover ticking from reset: release reset, idle 30 cycles -> oTick pulses every 10 cycles, oSpeed=0, oPeriod=9.
REQ-031 SHALL cover glitch rejection: iBtnn low for 3 cycles, then high -> no debounced edge, and oSpeed, oPaused and the tick spacing are unchanged.
REQ-032 SHALL cover short presses: three short presses (8 cycles each) -> oSpeed goes 1, 2, 0; tick spacing goes 5, 2, 10; each change restarts the counter and no tick occurs in the change cycle.
REQ-033 SHALL cover long press: hold 40 cycles, then release -> oPaused=1 exactly once, oTick stays 0, oSpeed is unchanged; a second long press -> oPaused=0 and the tick resumes from the held count.
REQ-034 SHALL cover a short press while paused: oSpeed advances, oTick stays 0, and after unpausing the spacing matches the new oPeriod.
REQ-035 SHALL cover reset mid-hold: pull RESETn low while the button is held 10 cycles, then release reset with the button still held -> all outputs equal the reset values, and no adv or toggle occurs until the button is released and pressed again.
